// File: rtl/axi4stream_sink_pkg.sv
// Shared types and constants for the AXI4-Stream sink/checker and its LFSR.
package axi4stream_sink_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_TAPS     = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

endpackage

// File: rtl/axi4stream_sink_chk_lfsr16.sv
// 16-bit Galois LFSR with seed load and zero-seed substitution.
// Exposes the next-state value so a caller can register decisions in step with the LFSR.
module lfsr16
    import axi4stream_sink_pkg::*;
#(
    parameter int OW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [15:0]   seed,
    input  logic          advance,
    output logic [OW-1:0] value_next
);

    logic [15:0] value;
    logic [15:0] nxt;

    // An all-zero state would lock the register, so a zero seed becomes the default.
    always_comb begin
        nxt = value;
        if (load) begin
            nxt = (seed == 16'h0000) ? LFSR_SEED_DEF : seed;
        end else if (advance) begin
            nxt = {1'b0, value[15:1]} ^ (value[0] ? LFSR_TAPS : 16'h0000);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= LFSR_SEED_DEF;
        end else begin
            value <= nxt;
        end
    end

    assign value_next = nxt[OW-1:0];

endmodule

// File: rtl/axi4stream_sink_chk.sv
// AXI4-Stream sink that applies programmable backpressure and checks beats
// against an incrementing reference, counting transfers and mismatches.
module axi4stream_sink_chk
    import axi4stream_sink_pkg::*;
#(
    parameter int DW = 8,
    parameter int CW = 16
) (
    input  logic          ACLK,
    input  logic          ARESET,
    input  logic          start,
    input  logic [CW-1:0] len,
    input  logic [DW-1:0] init,
    input  logic          rdy_mode,
    input  logic [7:0]    rdy_thr,
    input  logic [15:0]   seed,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    input  logic [DW-1:0] s_axis_tdata,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] xfer_cnt,
    output logic [CW-1:0] err_cnt,
    output logic          err_first,
    output logic [DW-1:0] err_exp,
    output logic [DW-1:0] err_got
);

    state_t        state;
    logic [CW-1:0] remaining;
    logic [DW-1:0] expected;
    logic [7:0]    lfsr_byte;
    logic          arm;
    logic          running;
    logic          accept;
    logic          last_beat;
    logic          mismatch;
    logic          rdy_next;

    assign arm       = (state == IDLE) && start;
    assign running   = (state == RUN);
    assign accept    = running && s_axis_tvalid && s_axis_tready;
    assign last_beat = accept && (remaining == CW'(1));
    assign mismatch  = (s_axis_tdata != expected);

    // The LFSR next value is the seed on the arming edge, so the first
    // TREADY decision after start already reflects the seeded pattern.
    assign rdy_next = rdy_mode ? (lfsr_byte < rdy_thr) : 1'b1;

    lfsr16 #(
        .OW(8)
    ) u_lfsr (
        .clk       (ACLK),
        .rst       (ARESET),
        .load      (arm),
        .seed      (seed),
        .advance   (running),
        .value_next(lfsr_byte)
    );

    // A length of zero wraps through all-ones, giving 2^CW beats.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state         <= IDLE;
            s_axis_tready <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            xfer_cnt      <= '0;
            err_cnt       <= '0;
            err_first     <= 1'b0;
            err_exp       <= '0;
            err_got       <= '0;
            remaining     <= '0;
            expected      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    s_axis_tready <= 1'b0;
                    if (start) begin
                        state         <= RUN;
                        busy          <= 1'b1;
                        remaining     <= len;
                        expected      <= init;
                        xfer_cnt      <= '0;
                        err_cnt       <= '0;
                        err_first     <= 1'b0;
                        err_exp       <= '0;
                        err_got       <= '0;
                        s_axis_tready <= rdy_next;
                    end
                end
                RUN: begin
                    s_axis_tready <= rdy_next && !last_beat;
                    if (accept) begin
                        xfer_cnt  <= xfer_cnt + CW'(1);
                        expected  <= expected + DW'(1);
                        remaining <= remaining - CW'(1);
                        if (mismatch) begin
                            if (err_cnt != '1) begin
                                err_cnt <= err_cnt + CW'(1);
                            end
                            if (!err_first) begin
                                err_first <= 1'b1;
                                err_exp   <= expected;
                                err_got   <= s_axis_tdata;
                            end
                        end
                    end
                    if (last_beat) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state         <= IDLE;
                    s_axis_tready <= 1'b0;
                end
                default: begin
                    state         <= IDLE;
                    s_axis_tready <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4stream_sink_chk.sv
// Scoreboard-driven bench for axi4stream_sink_chk: per-beat expected counts are
// queued as beats are offered and compared once the DUT has taken them.
module tb_axi4stream_sink_chk;

    localparam int DW = 8;
    localparam int CW = 16;

    logic          ACLK = 1'b0;
    logic          ARESET = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] len = '0;
    logic [DW-1:0] init = '0;
    logic          rdy_mode = 1'b0;
    logic [7:0]    rdy_thr = 8'd0;
    logic [15:0]   seed = 16'h0000;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          busy;
    logic          done;
    logic [CW-1:0] xfer_cnt;
    logic [CW-1:0] err_cnt;
    logic          err_first;
    logic [DW-1:0] err_exp;
    logic [DW-1:0] err_got;

    typedef struct {
        logic [CW-1:0] xfer;
        logic [CW-1:0] errs;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int tests_run = 0;
    int tests_failed = 0;
    int busy_cycles = 0;
    int rdy_cycles = 0;
    int done_count = 0;
    int stray_accepts = 0;

    axi4stream_sink_chk #(
        .DW(DW),
        .CW(CW)
    ) dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .start        (start),
        .len          (len),
        .init         (init),
        .rdy_mode     (rdy_mode),
        .rdy_thr      (rdy_thr),
        .seed         (seed),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tdata (s_axis_tdata),
        .busy         (busy),
        .done         (done),
        .xfer_cnt     (xfer_cnt),
        .err_cnt      (err_cnt),
        .err_first    (err_first),
        .err_exp      (err_exp),
        .err_got      (err_got)
    );

    always #5 ACLK = ~ACLK;

    // Activity statistics sampled mid-cycle, read by tests only after a later edge.
    always @(negedge ACLK) begin
        if (busy) begin
            busy_cycles++;
            if (s_axis_tready) rdy_cycles++;
        end
        if (done) done_count++;
        if (s_axis_tvalid && s_axis_tready && !busy) stray_accepts++;
    end

    task automatic apply_reset();
        ARESET = 1'b1;
        start = 1'b0;
        s_axis_tvalid = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        sb_q.delete();
    endtask

    task automatic pulse_start(input logic [CW-1:0] l, input logic [DW-1:0] i,
                               input logic m, input logic [7:0] thr, input logic [15:0] sd);
        sb_q.delete();
        len = l;
        init = i;
        rdy_mode = m;
        rdy_thr = thr;
        seed = sd;
        start = 1'b1;
        @(posedge ACLK);
        #1;
        start = 1'b0;
    endtask

    // Offers n incrementing beats; returns at mid-cycle after the last accepted beat.
    task automatic drive_stream(input int n, input logic [DW-1:0] first,
                                input int bad_idx, input logic [DW-1:0] bad_val,
                                input int gap_at, input int start_at,
                                input int max_cycles, output int cycles_used);
        int k = 0;
        int cyc = 0;
        int errs = 0;
        int gap_left = 0;
        bit gap_used = 0;
        bit start_done = 0;
        bit have_beat = 0;
        bit pend = 0;
        bit rd;
        logic [DW-1:0] ref_val;
        sb_entry_t e;
        while (1) begin
            if (k < n) begin
                if (k == gap_at && !gap_used) begin
                    gap_used = 1;
                    gap_left = 3;
                end
                if (gap_left > 0) begin
                    s_axis_tvalid = 1'b0;
                    gap_left--;
                end else if (!have_beat) begin
                    ref_val = first + DW'(k);
                    s_axis_tdata = (k == bad_idx) ? bad_val : ref_val;
                    s_axis_tvalid = 1'b1;
                    if (s_axis_tdata !== ref_val) errs++;
                    e.xfer = CW'(k + 1);
                    e.errs = CW'(errs);
                    sb_q.push_back(e);
                    have_beat = 1;
                end
                if (k == start_at && !start_done) begin
                    start = 1'b1;
                    len = CW'(3);
                    init = 8'hAA;
                    start_done = 1;
                end
            end
            @(negedge ACLK);
            if (pend) begin
                pend = 0;
                tests_run++;
                if (sb_q.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL sb_underflow: beat accepted with no queued expectation");
                end else begin
                    e = sb_q.pop_front();
                    if (xfer_cnt !== e.xfer || err_cnt !== e.errs) begin
                        tests_failed++;
                        $display("[TB] FAIL sb_beat: xfer_cnt=%0d err_cnt=%0d, expected xfer_cnt=%0d err_cnt=%0d",
                                 xfer_cnt, err_cnt, e.xfer, e.errs);
                    end
                end
            end
            if (k >= n || cyc >= max_cycles) break;
            rd = s_axis_tvalid && s_axis_tready;
            @(posedge ACLK);
            #1;
            cyc++;
            start = 1'b0;
            if (rd) begin
                k++;
                pend = 1;
                have_beat = 0;
            end
        end
        s_axis_tvalid = 1'b0;
        start = 1'b0;
        cycles_used = cyc;
        tests_run++;
        if (k != n) begin
            tests_failed++;
            $display("[TB] FAIL stream_accepts: accepted %0d beats within %0d cycles, expected %0d", k, cyc, n);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge ACLK);
        #1;
        tests_run++;
        if ({s_axis_tready, busy, done} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl: tready/busy/done=%b, expected 000", {s_axis_tready, busy, done});
        end
        tests_run++;
        if (xfer_cnt !== '0 || err_cnt !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_counts: xfer_cnt=%0d err_cnt=%0d, expected 0 0", xfer_cnt, err_cnt);
        end
        tests_run++;
        if (err_first !== 1'b0 || err_exp !== '0 || err_got !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_err: err_first=%b err_exp=%h err_got=%h, expected 0 00 00",
                     err_first, err_exp, err_got);
        end
        ARESET = 1'b0;
        @(posedge ACLK);
        #1;
    endtask

    task automatic test_clean_run();
        int cyc;
        int d0 = done_count;
        pulse_start(CW'(16), 8'hF8, 1'b0, 8'd0, 16'h0000);
        tests_run++;
        if (busy !== 1'b1 || s_axis_tready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL clean_arm: busy=%b tready=%b, expected 1 1", busy, s_axis_tready);
        end
        drive_stream(16, 8'hF8, -1, 8'h00, -1, -1, 100, cyc);
        tests_run++;
        if (cyc != 16) begin
            tests_failed++;
            $display("[TB] FAIL clean_throughput: %0d cycles, expected 16", cyc);
        end
        tests_run++;
        if ({done, busy, s_axis_tready} !== 3'b100) begin
            tests_failed++;
            $display("[TB] FAIL clean_done: done/busy/tready=%b, expected 100", {done, busy, s_axis_tready});
        end
        tests_run++;
        if (xfer_cnt !== CW'(16) || err_cnt !== '0 || err_first !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL clean_counts: xfer=%0d err=%0d first=%b, expected 16 0 0", xfer_cnt, err_cnt, err_first);
        end
        @(posedge ACLK);
        #1;
        tests_run++;
        if (done !== 1'b0 || s_axis_tready !== 1'b0 || (done_count - d0) != 1) begin
            tests_failed++;
            $display("[TB] FAIL clean_pulse: done=%b tready=%b pulses=%0d, expected 0 0 1",
                     done, s_axis_tready, done_count - d0);
        end
    endtask

    task automatic test_single_error();
        int cyc;
        pulse_start(CW'(8), 8'h00, 1'b0, 8'd0, 16'h0000);
        drive_stream(8, 8'h00, 3, 8'h55, -1, -1, 100, cyc);
        @(posedge ACLK);
        #1;
        tests_run++;
        if (xfer_cnt !== CW'(8) || err_cnt !== CW'(1) || err_first !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL err_counts: xfer=%0d err=%0d first=%b, expected 8 1 1", xfer_cnt, err_cnt, err_first);
        end
        tests_run++;
        if (err_exp !== 8'h03 || err_got !== 8'h55) begin
            tests_failed++;
            $display("[TB] FAIL err_capture: exp=%h got=%h, expected 03 55", err_exp, err_got);
        end
    endtask

    task automatic test_random_backpressure();
        int cyc;
        int b0 = busy_cycles;
        int r0 = rdy_cycles;
        int s0 = stray_accepts;
        int bc;
        int rc;
        pulse_start(CW'(100), 8'h00, 1'b1, 8'd128, 16'h1234);
        drive_stream(100, 8'h00, -1, 8'h00, -1, -1, 2000, cyc);
        tests_run++;
        if (done !== 1'b1 || xfer_cnt !== CW'(100) || err_cnt !== '0) begin
            tests_failed++;
            $display("[TB] FAIL rand_run: done=%b xfer=%0d err=%0d, expected 1 100 0", done, xfer_cnt, err_cnt);
        end
        s_axis_tvalid = 1'b1;
        repeat (5) @(posedge ACLK);
        #1;
        s_axis_tvalid = 1'b0;
        bc = busy_cycles - b0;
        rc = rdy_cycles - r0;
        tests_run++;
        if (xfer_cnt !== CW'(100) || stray_accepts != s0) begin
            tests_failed++;
            $display("[TB] FAIL rand_after_last: xfer=%0d stray=%0d, expected 100 0", xfer_cnt, stray_accepts - s0);
        end
        tests_run++;
        if (rc * 100 < bc * 40 || rc * 100 > bc * 60) begin
            tests_failed++;
            $display("[TB] FAIL rand_duty: ready %0d of %0d busy cycles, expected 40-60 percent", rc, bc);
        end
    endtask

    task automatic test_edge_thresholds();
        logic [39:0] seq_a;
        logic [39:0] seq_b;
        int r0 = rdy_cycles;
        pulse_start(CW'(10), 8'h00, 1'b1, 8'd0, 16'h1234);
        s_axis_tvalid = 1'b1;
        s_axis_tdata = 8'h00;
        repeat (200) @(posedge ACLK);
        #1;
        tests_run++;
        if (xfer_cnt !== '0 || busy !== 1'b1 || rdy_cycles != r0) begin
            tests_failed++;
            $display("[TB] FAIL thr_zero: xfer=%0d busy=%b ready_cycles=%0d, expected 0 1 0",
                     xfer_cnt, busy, rdy_cycles - r0);
        end
        apply_reset();
        pulse_start(CW'(50), 8'h00, 1'b1, 8'd128, 16'h0000);
        for (int i = 0; i < 40; i++) begin
            @(negedge ACLK);
            seq_a[i] = s_axis_tready;
        end
        apply_reset();
        pulse_start(CW'(50), 8'h00, 1'b1, 8'd128, 16'hACE1);
        for (int i = 0; i < 40; i++) begin
            @(negedge ACLK);
            seq_b[i] = s_axis_tready;
        end
        apply_reset();
        tests_run++;
        if (seq_a !== seq_b) begin
            tests_failed++;
            $display("[TB] FAIL seed_zero: tready pattern %h, expected %h", seq_a, seq_b);
        end
        tests_run++;
        if (seq_a == 40'h0 || seq_a == {40{1'b1}}) begin
            tests_failed++;
            $display("[TB] FAIL seed_pattern: tready pattern %h, expected a mix of 0 and 1", seq_a);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        int d0 = done_count;
        pulse_start(CW'(10), 8'h20, 1'b0, 8'd0, 16'h0000);
        drive_stream(5, 8'h20, -1, 8'h00, -1, -1, 100, cyc);
        ARESET = 1'b1;
        @(negedge ACLK);
        tests_run++;
        if ({s_axis_tready, busy, done} !== 3'b000 || xfer_cnt !== '0 || err_cnt !== '0) begin
            tests_failed++;
            $display("[TB] FAIL abort_state: tready/busy/done=%b xfer=%0d err=%0d, expected 000 0 0",
                     {s_axis_tready, busy, done}, xfer_cnt, err_cnt);
        end
        ARESET = 1'b0;
        @(posedge ACLK);
        #1;
        pulse_start(CW'(4), 8'h10, 1'b0, 8'd0, 16'h0000);
        drive_stream(4, 8'h10, -1, 8'h00, -1, -1, 100, cyc);
        @(posedge ACLK);
        #1;
        tests_run++;
        if (xfer_cnt !== CW'(4) || err_cnt !== '0 || (done_count - d0) != 1) begin
            tests_failed++;
            $display("[TB] FAIL abort_restart: xfer=%0d err=%0d pulses=%0d, expected 4 0 1",
                     xfer_cnt, err_cnt, done_count - d0);
        end
    endtask

    task automatic test_ignored_start_and_gap();
        int cyc;
        int d0 = done_count;
        pulse_start(CW'(12), 8'h40, 1'b0, 8'd0, 16'h0000);
        drive_stream(12, 8'h40, -1, 8'h00, 6, 2, 100, cyc);
        tests_run++;
        if (cyc != 15 || done !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL gap_timing: %0d cycles done=%b, expected 15 1", cyc, done);
        end
        @(posedge ACLK);
        #1;
        tests_run++;
        if (xfer_cnt !== CW'(12) || err_cnt !== '0 || err_first !== 1'b0 || (done_count - d0) != 1) begin
            tests_failed++;
            $display("[TB] FAIL gap_counts: xfer=%0d err=%0d first=%b pulses=%0d, expected 12 0 0 1",
                     xfer_cnt, err_cnt, err_first, done_count - d0);
        end
    endtask

    initial begin
        test_reset();
        test_clean_run();
        test_single_error();
        test_random_backpressure();
        test_edge_thresholds();
        test_reset_mid_run();
        test_ignored_start_and_gap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached with %0d failures so far, expected completion", tests_failed);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/axi4stream_sink_chk.md
# axi4stream_sink_chk

Synthesizable AXI4-Stream receiver and checker. It sits at the far end of an AXI4-Stream source, for example the master VIP or a DUT output, and drives TREADY with a programmable backpressure pattern. Every accepted beat is checked against an incrementing reference sequence. The block counts transfers and mismatches, captures the first mismatch, and flags completion after a programmed number of beats.

## Interface
Parameters:
- DW, 8: TDATA width in bits (1..64).
- CW, 16: width of the length counter, transfer counter and error counter.

Ports:
- ACLK  in  1  single clock; all logic on rising edge.
- ARESET  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; arms a run (ignored while a run is active).
- len  in  CW  number of beats to accept per run; sampled on start; 0 is treated as 2^CW.
- init  in  DW  first expected TDATA value; sampled on start.
- rdy_mode  in  1  0 = TREADY held high while running; 1 = pseudo-random TREADY.
- rdy_thr  in  8  random mode: TREADY=1 when LFSR[7:0] < rdy_thr (0 = never ready, 255 ≈ 99.6%).
- seed  in  16  LFSR seed; loaded on start; 0 is replaced by 16'hACE1.
- s_axis_tvalid  in  1  AXI4-Stream TVALID.
- s_axis_tready  out  1  AXI4-Stream TREADY, registered.
- s_axis_tdata  in  DW  AXI4-Stream TDATA.
- busy  out  1  run active.
- done  out  1  one-cycle pulse after the last beat.
- xfer_cnt  out  CW  beats accepted in the current or last run.
- err_cnt  out  CW  mismatching beats; saturates at all-ones.
- err_first  out  1  at least one mismatch seen in this run (sticky until next start).
- err_exp / err_got  out  DW/DW  expected and received data of the first mismatch.

## Operation
- States are IDLE, RUN and DONE.
- IDLE: TREADY=0. On start, the block loads the remaining count, expected value and LFSR; clears xfer_cnt, err_cnt, err_first, err_exp and err_got; then moves to RUN.
- RUN: a beat is accepted when s_axis_tvalid && s_axis_tready. On each accepted beat:
  - xfer_cnt increments.
  - expected increments by 1, modulo 2^DW, with wrap from all-ones to 0.
  - The remaining count decrements.
- On a mismatch, err_cnt increments (saturating). On the first mismatch of a run, err_exp and err_got are captured and err_first is set. Expected still advances, with no resynchronisation to received data.
- When the accepted beat is the last one (remaining == 1), the next state is DONE.
- DONE: lasts exactly one cycle. done=1, TREADY=0, then return to IDLE. Counters hold their values until the next start.
- LFSR: 16-bit Galois, taps 16,14,13,11. It advances every cycle in RUN, independent of TVALID.
- TREADY is the registered value for the next cycle:
  - rdy_mode=0: 1 while RUN and not on the last accepted beat.
  - rdy_mode=1: (LFSR[7:0] < rdy_thr), under the same RUN and not-last conditions.
- TREADY never depends combinationally on TVALID.
- start during RUN or DONE is ignored.

## Timing
- Reset values: s_axis_tready=0, busy=0, done=0, xfer_cnt=0, err_cnt=0, err_first=0, err_exp=0, err_got=0, state=IDLE.
- Reset mid-run aborts immediately: all outputs return to reset values on the next edge. No done pulse is produced.
- Start is seen at edge N, and busy=1 from N+1.
  - rdy_mode=0: TREADY=1 from N+1.
  - rdy_mode=1: the first TREADY is evaluated from the seeded LFSR, so it is visible from N+1.
- Last beat is accepted at edge M:
  - TREADY=0 from M+1, so no extra beat is accepted.
  - done=1 and busy=0 during cycle M+1 (DONE state). IDLE from M+2.
- Counters and err_* update on the same edge as the accepting transfer. They are visible one cycle after the beat.
- Maximum throughput is 1 beat per cycle in mode 0.

## Structure
- Package axi4stream_sink_pkg holds:
  - state_t enum (IDLE, RUN, DONE).
  - LFSR_TAPS constant (16'hB400).
  - LFSR_SEED_DEF constant (16'hACE1).
- Sub-module lfsr16 holds the load, seed and advance logic, with seed-zero substitution. It is reusable by a future source-side generator.
- Top module: FSM, TREADY register, expected/remaining/error datapath.

## Test plan
- Clean run: mode 0, len=16, init=8'hF8, source sends F8..FF,00..07 back-to-back → 16 beats in 16 cycles, wrap passes, xfer_cnt=16, err_cnt=0, done pulse 1 cycle after the 16th beat, TREADY=0 afterwards.
- Single error: len=8, init=0, beat 3 sent as 8'h55 → err_cnt=1, err_first=1, err_exp=8'h03, err_got=8'h55, remaining beats 4..7 pass.
- Random backpressure: mode 1, rdy_thr=128, seed=16'h1234, len=100, source always valid → exactly 100 beats accepted, all match, TREADY duty 40–60%, no acceptance after the last beat.
- Edge thresholds: rdy_thr=0 → no beat accepted in 200 cycles and busy stays 1. Seed=0 behaves identically to seed=16'hACE1.
- Reset mid-run: ARESET asserted after 5 of 10 beats → next cycle TREADY=0, busy=0, counters 0, no done. A new start then completes normally.
- Ignored start and source gaps: start pulsed during RUN has no effect. TVALID low for 3 cycles mid-stream → expected value unchanged across the gap, err_cnt=0.
